// File: rtl/spi_regfile_peripheral.sv
// spi_regfile_peripheral
//
// SPI mode-0 register-file peripheral. The host sends a 1 + ADDR_W + DATA_W bit
// frame, MSB first: the R/W flag (1 = write), the address, then the data field.
// A write commits to the addressed register when chip select is released. A read
// returns the addressed register on cipo during the data phase. Malformed frames
// and out-of-range addresses bump a saturating error counter.
//
// Ports:
//   clk        system clock, the only clock in the block
//   rst        synchronous active-high reset
//   sclk       SPI clock from the host (asynchronous to clk)
//   copi       SPI data from the host
//   ncs        SPI chip select, active-low
//   cipo       SPI data to the host
//   cipo_oe    output enable for the cipo pad
//   regs_out   flattened registers, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe  one-cycle pulse when a write commits
//   wr_addr    address of the last committed write
//   err_count  saturating count of rejected frames
module spi_regfile_peripheral #(
  parameter int                NUM_REGS    = 5,
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 7,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [7:0]                   err_count
);

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 2);

  localparam logic [CNT_W-1:0]  FRAME_C = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0]  HDR_C   = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0]  HDR_M1  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  SAT_C   = CNT_W'(FRAME + 1);
  localparam logic [ADDR_W:0]   NREGS_C = (ADDR_W + 1)'(NUM_REGS);

  // Synchronizer chains; the last stage of each is the delayed copy used
  // for edge detection.
  logic [SYNC_STAGES:0] sclk_q;
  logic [SYNC_STAGES:0] copi_q;
  logic [SYNC_STAGES:0] ncs_q;

  logic sclk_s, sclk_d, ncs_s, ncs_d, copi_s;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME-1:0]   rx_shift;
  logic [DATA_W-1:0]  tx_shift;

  // Set by reset and held until chip select is seen high, so the tail of a
  // frame interrupted by reset is dropped instead of being decoded.
  logic discard;

  logic [FRAME-1:0]   rx_next;
  logic               hdr_rw;
  logic [ADDR_W-1:0]  hdr_addr;
  logic [DATA_W-1:0]  rd_data;
  logic               frame_rw;
  logic [ADDR_W-1:0]  frame_addr;
  logic [DATA_W-1:0]  frame_data;
  logic               frame_valid;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign sclk_d = sclk_q[SYNC_STAGES];
  assign ncs_s  = ncs_q[SYNC_STAGES-1];
  assign ncs_d  = ncs_q[SYNC_STAGES];
  // copi is taken from the delayed stage; the host holds it stable for half
  // an sclk period around the rising edge, far longer than one clk.
  assign copi_s = copi_q[SYNC_STAGES];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  // The pad is driven only while the host selects us; the discard gate keeps
  // it off while the freshly reset synchronizer still reads ncs as low.
  assign cipo_oe = ~ncs_s & ~discard;

  // tx_shift holds zeros except during a read data phase.
  assign cipo = tx_shift[DATA_W-1];

  // Header decode looks at the shift register as it will be after the current
  // sclk rising edge, so a read can be loaded on the edge that completes the
  // address. Frame decode looks at the completed shift register at ncs rise.
  always_comb begin
    rx_next     = {rx_shift[FRAME-2:0], copi_s};
    hdr_rw      = rx_next[ADDR_W];
    hdr_addr    = rx_next[ADDR_W-1:0];
    frame_rw    = rx_shift[FRAME-1];
    frame_addr  = rx_shift[FRAME-2 -: ADDR_W];
    frame_data  = rx_shift[DATA_W-1:0];
    frame_valid = ({1'b0, frame_addr} < NREGS_C);
    rd_data     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hdr_addr == ADDR_W'(i)) begin
        rd_data = regs_out[i*DATA_W +: DATA_W];
      end
    end
  end

  // Main sequential block: synchronizers, bit sampling, readback shifting and
  // frame-end commit/error handling. A new ncs fall always restarts the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q    <= '0;
      copi_q    <= '0;
      ncs_q     <= '0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      discard   <= 1'b1;
      regs_out  <= {NUM_REGS{RESET_VAL}};
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      err_count <= '0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-1:0], sclk};
      copi_q    <= {copi_q[SYNC_STAGES-1:0], copi};
      ncs_q     <= {ncs_q[SYNC_STAGES-1:0], ncs};
      wr_strobe <= 1'b0;

      if (ncs_s) begin
        discard <= 1'b0;
      end

      if (!discard) begin
        if (ncs_fall) begin
          bit_cnt  <= '0;
          rx_shift <= '0;
          tx_shift <= '0;
        end else if (ncs_rise) begin
          if (bit_cnt == FRAME_C && frame_valid) begin
            if (frame_rw) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (frame_addr == ADDR_W'(i)) begin
                  regs_out[i*DATA_W +: DATA_W] <= frame_data;
                end
              end
              wr_strobe <= 1'b1;
              wr_addr   <= frame_addr;
            end
          end else if (bit_cnt != '0) begin
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end
          bit_cnt  <= '0;
          rx_shift <= '0;
          tx_shift <= '0;
        end else if (!ncs_s) begin
          if (sclk_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt != SAT_C) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
            if (bit_cnt == HDR_M1 && !hdr_rw) begin
              tx_shift <= rd_data;
            end
          end else if (sclk_fall && bit_cnt > HDR_C) begin
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Testbench for spi_regfile_peripheral: a table of SPI frames with expected
// register file, error count, strobe count and readback data, followed by
// hand-written sequences for error saturation, mid-frame reset and
// back-to-back writes.
module tb_spi_regfile_peripheral;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int HALF     = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        sclk;
  logic                        copi;
  logic                        ncs;
  logic                        cipo;
  logic                        cipo_oe;
  logic [NUM_REGS*DATA_W-1:0]  regs_out;
  logic                        wr_strobe;
  logic [ADDR_W-1:0]           wr_addr;
  logic [7:0]                  err_count;

  int nvec  = 0;
  int nmiss = 0;
  int strobe_cnt = 0;

  spi_regfile_peripheral #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .SYNC_STAGES(2), .RESET_VAL(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Counts clk cycles with wr_strobe high; a stuck strobe shows up as extra.
  always @(posedge clk) begin
    if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  typedef struct {
    int          nbits;
    logic [31:0] bits;
    logic        is_read;
    logic [7:0]  exp_rd;
    logic [39:0] exp_regs;
    logic [7:0]  exp_err;
    int          exp_strobes;
    logic [6:0]  exp_wr_addr;
  } vec_t;

  vec_t vecs[12];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one SPI mode-0 frame of nbits bits (MSB of the nbits-wide value
  // first). cipo is sampled at the end of each low phase, just before the
  // rising edge, for frame bits 8..15. rst_after >= 0 pulses reset before
  // that bit is driven.
  task automatic applyStimulus(input int nbits, input logic [31:0] bits,
                               input int ncs_high, input int rst_after,
                               output logic [7:0] rd, output logic oe_mid);
    logic [31:0] sh;
    sh = (nbits == 0) ? 32'h0 : (bits << (32 - nbits));
    rd = 8'h00;
    oe_mid = 1'b0;
    ncs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_after) begin
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
      end
      copi = sh[31];
      sh = sh << 1;
      wait_clk(HALF);
      if (i >= 8 && i < 16) rd = {rd[6:0], cipo};
      if (i == nbits / 2) oe_mid = cipo_oe;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
    ncs = 1'b1;
    copi = 1'b0;
    wait_clk(ncs_high);
  endtask

  initial begin
    logic [7:0] rd;
    logic       oe_mid;
    int         s0;

    //           nbits bits           rd  exp_rd  exp_regs         err    strb wr_addr
    vecs[0]  = '{16, 32'h0000_82AA, 1'b0, 8'h00, 40'h00_00_AA_00_00, 8'd0, 1, 7'd2};
    vecs[1]  = '{16, 32'h0000_843C, 1'b0, 8'h00, 40'h3C_00_AA_00_00, 8'd0, 1, 7'd4};
    vecs[2]  = '{16, 32'h0000_0400, 1'b1, 8'h3C, 40'h3C_00_AA_00_00, 8'd0, 0, 7'd4};
    vecs[3]  = '{16, 32'h0000_0200, 1'b1, 8'hAA, 40'h3C_00_AA_00_00, 8'd0, 0, 7'd4};
    vecs[4]  = '{16, 32'h0000_8555, 1'b0, 8'h00, 40'h3C_00_AA_00_00, 8'd1, 0, 7'd4};
    vecs[5]  = '{16, 32'h0000_0900, 1'b1, 8'h00, 40'h3C_00_AA_00_00, 8'd2, 0, 7'd4};
    vecs[6]  = '{15, 32'h0000_7FFF, 1'b0, 8'h00, 40'h3C_00_AA_00_00, 8'd3, 0, 7'd4};
    vecs[7]  = '{17, 32'h0001_FFFF, 1'b0, 8'h00, 40'h3C_00_AA_00_00, 8'd4, 0, 7'd4};
    vecs[8]  = '{0,  32'h0000_0000, 1'b0, 8'h00, 40'h3C_00_AA_00_00, 8'd4, 0, 7'd4};
    vecs[9]  = '{16, 32'h0000_0000, 1'b1, 8'h00, 40'h3C_00_AA_00_00, 8'd4, 0, 7'd4};
    vecs[10] = '{16, 32'h0000_83C3, 1'b0, 8'h00, 40'h3C_C3_AA_00_00, 8'd4, 1, 7'd3};
    vecs[11] = '{16, 32'h0000_0300, 1'b1, 8'hC3, 40'h3C_C3_AA_00_00, 8'd4, 0, 7'd3};

    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    wait_clk(3);
    checkOutput("reset regs_out", 64'(regs_out), 64'h0);
    checkOutput("reset cipo", 64'(cipo), 64'h0);
    checkOutput("reset cipo_oe", 64'(cipo_oe), 64'h0);
    checkOutput("reset wr_strobe", 64'(wr_strobe), 64'h0);
    checkOutput("reset wr_addr", 64'(wr_addr), 64'h0);
    checkOutput("reset err_count", 64'(err_count), 64'h0);
    rst = 1'b0;
    wait_clk(6);
    checkOutput("idle cipo_oe", 64'(cipo_oe), 64'h0);

    for (int v = 0; v < 12; v++) begin
      s0 = strobe_cnt;
      applyStimulus(vecs[v].nbits, vecs[v].bits, 10, -1, rd, oe_mid);
      checkOutput($sformatf("vec%0d regs_out", v), 64'(regs_out), 64'(vecs[v].exp_regs));
      checkOutput($sformatf("vec%0d err_count", v), 64'(err_count), 64'(vecs[v].exp_err));
      checkOutput($sformatf("vec%0d wr_strobe cycles", v), 64'(strobe_cnt - s0),
                  64'(vecs[v].exp_strobes));
      checkOutput($sformatf("vec%0d wr_addr", v), 64'(wr_addr), 64'(vecs[v].exp_wr_addr));
      checkOutput($sformatf("vec%0d cipo_oe after", v), 64'(cipo_oe), 64'h0);
      if (vecs[v].nbits > 0)
        checkOutput($sformatf("vec%0d cipo_oe mid", v), 64'(oe_mid), 64'h1);
      if (vecs[v].is_read)
        checkOutput($sformatf("vec%0d readback", v), 64'(rd), 64'(vecs[v].exp_rd));
    end

    // 256 one-bit frames on top of the 4 errors so far must pin the count at 255.
    for (int k = 0; k < 256; k++) begin
      applyStimulus(1, 32'h1, 10, -1, rd, oe_mid);
    end
    checkOutput("err_count saturated", 64'(err_count), 64'd255);
    checkOutput("regs after bad frames", 64'(regs_out), 64'h3C_C3_AA_00_00);

    // Reset after 10 bits of a write to addr 1 (0x77): the frame is dropped.
    s0 = strobe_cnt;
    applyStimulus(16, 32'h0000_8177, 10, 10, rd, oe_mid);
    checkOutput("mid-reset regs_out", 64'(regs_out), 64'h0);
    checkOutput("mid-reset err_count", 64'(err_count), 64'h0);
    checkOutput("mid-reset wr_strobe cycles", 64'(strobe_cnt - s0), 64'h0);
    checkOutput("mid-reset wr_addr", 64'(wr_addr), 64'h0);
    s0 = strobe_cnt;
    applyStimulus(16, 32'h0000_8177, 10, -1, rd, oe_mid);
    checkOutput("post-reset regs_out", 64'(regs_out), 64'h00_00_00_77_00);
    checkOutput("post-reset wr_addr", 64'(wr_addr), 64'd1);
    checkOutput("post-reset wr_strobe cycles", 64'(strobe_cnt - s0), 64'd1);

    // Back-to-back writes with minimum chip-select high time.
    s0 = strobe_cnt;
    applyStimulus(16, 32'h0000_8011, 5, -1, rd, oe_mid);
    applyStimulus(16, 32'h0000_8122, 5, -1, rd, oe_mid);
    wait_clk(5);
    checkOutput("b2b regs_out", 64'(regs_out), 64'h00_00_00_22_11);
    checkOutput("b2b wr_strobe cycles", 64'(strobe_cnt - s0), 64'd2);
    checkOutput("b2b wr_addr", 64'(wr_addr), 64'd1);
    checkOutput("b2b err_count", 64'(err_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
